// File: rtl/decode_pkg.sv
// ----------------------------------------------------------------------------
// decode_pkg
// Constants and helpers that the decode unit and its issue arbiter share.
//   ADDR_W / INST_W / PID_W / TID_W / MAJ_ID_W : default field widths
//   clog2      : index width for a count of items (never less than 1 bit)
//   field_lsb  : LSB of one thread's field in a packed per-thread vector,
//                with thread 0 at the MSBs
// ----------------------------------------------------------------------------
package decode_pkg;

    localparam int ADDR_W   = 64;
    localparam int INST_W   = 32;
    localparam int PID_W    = 20;
    localparam int TID_W    = 16;
    localparam int MAJ_ID_W = 64;

    // Minimum of 1 so that a single-entry index still gets a real bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int field_lsb(input int thread, input int num_threads, input int width);
        return (num_threads - 1 - thread) * width;
    endfunction

endpackage

// File: rtl/decode_thread_queue.sv
// ----------------------------------------------------------------------------
// decode_thread_queue
// Single-thread synchronous FIFO that holds fetched instructions for one thread.
// The head entry is presented combinationally.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   push_i, push_data_i : write request and data (ignored while full)
//   pop_i            : read request (ignored while empty)
//   flush_i          : empty the queue; overrides push and pop
//   full_o, empty_o  : status from registered occupancy
//   head_o           : oldest entry
// ----------------------------------------------------------------------------
module decode_thread_queue
    import decode_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int PTR_W = clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Full comes from the registered count, so a pop in the same cycle does
    // not make room for a push into a full queue.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/decode_issue_arbiter.sv
// ----------------------------------------------------------------------------
// decode_issue_arbiter
// Shares one decode unit between numThreads fetch streams. Each thread has a
// small queue; a round-robin scheduler pops one head per cycle onto a
// registered interface that drives the decoder inputs, stamping it with a
// global major ID. Honours decoder stall and per-thread flush.
// Ports:
//   clock_i, reset_i          : clock, synchronous active-high reset
//   fetch*_i / fetchReady_o   : per-thread push interface (thread 0 at MSBs
//                               of packed vectors, bit t for 1-bit vectors)
//   flush_i                   : per-thread queue flush
//   stall_i                   : decoder cannot accept
//   enable_o, instruction*_o, is64Bit_o : registered issue to the decoder
//   grantThread_o             : thread of the current issue
// Optional build macro DECODE_ARB_PERF_EN adds issueCount_o and
// stallCycles_o (saturating 32-bit counters).
// ----------------------------------------------------------------------------
module decode_issue_arbiter
    import decode_pkg::*;
#(
    parameter int addressWidth            = ADDR_W,
    parameter int instructionWidth        = INST_W,
    parameter int PidSize                 = PID_W,
    parameter int TidSize                 = TID_W,
    parameter int instructionCounterWidth = MAJ_ID_W,
    parameter int numThreads              = 2,
    parameter int queueDepth              = 4,
    localparam int TW                     = clog2(numThreads)
) (
    input  logic                                   clock_i,
    input  logic                                   reset_i,
    input  logic [numThreads-1:0]                  fetchValid_i,
    output logic [numThreads-1:0]                  fetchReady_o,
    input  logic [numThreads*instructionWidth-1:0] fetchInst_i,
    input  logic [numThreads*addressWidth-1:0]     fetchAddr_i,
    input  logic [numThreads-1:0]                  fetchIs64Bit_i,
    input  logic [numThreads*PidSize-1:0]          fetchPid_i,
    input  logic [numThreads*TidSize-1:0]          fetchTid_i,
    input  logic [numThreads-1:0]                  flush_i,
    input  logic                                   stall_i,
    output logic                                   enable_o,
    output logic [instructionWidth-1:0]            instruction_o,
    output logic [addressWidth-1:0]                instructionAddress_o,
    output logic                                   is64Bit_o,
    output logic [PidSize-1:0]                     instructionPid_o,
    output logic [TidSize-1:0]                     instructionTid_o,
    output logic [instructionCounterWidth-1:0]     instructionMajId_o,
    output logic [TW-1:0]                          grantThread_o
`ifdef DECODE_ARB_PERF_EN
    ,
    output logic [31:0]                            issueCount_o,
    output logic [31:0]                            stallCycles_o
`endif
);

    typedef struct packed {
        logic [instructionWidth-1:0] inst;
        logic [addressWidth-1:0]     addr;
        logic                        is64;
        logic [PidSize-1:0]          pid;
        logic [TidSize-1:0]          tid;
    } entry_t;

    entry_t                  push_data [numThreads];
    entry_t                  head      [numThreads];
    logic [numThreads-1:0]   full, empty, push, pop, eligible;

    genvar t;
    generate
        for (t = 0; t < numThreads; t++) begin : g_queue
            assign push_data[t].inst = fetchInst_i[field_lsb(t, numThreads, instructionWidth) +: instructionWidth];
            assign push_data[t].addr = fetchAddr_i[field_lsb(t, numThreads, addressWidth) +: addressWidth];
            assign push_data[t].is64 = fetchIs64Bit_i[t];
            assign push_data[t].pid  = fetchPid_i[field_lsb(t, numThreads, PidSize) +: PidSize];
            assign push_data[t].tid  = fetchTid_i[field_lsb(t, numThreads, TidSize) +: TidSize];

            decode_thread_queue #(
                .DATA_W ($bits(entry_t)),
                .DEPTH  (queueDepth)
            ) u_queue (
                .clk_i       (clock_i),
                .rst_i       (reset_i),
                .push_i      (push[t]),
                .push_data_i (push_data[t]),
                .pop_i       (pop[t]),
                .flush_i     (flush_i[t]),
                .full_o      (full[t]),
                .empty_o     (empty[t]),
                .head_o      (head[t])
            );
        end
    endgenerate

    assign fetchReady_o = ~full & {numThreads{~reset_i}};
    assign push         = fetchValid_i & fetchReady_o;
    // A thread being flushed this cycle must not issue its soon-to-vanish head.
    assign eligible     = ~empty & ~flush_i;

    logic                               enable_q, enable_d;
    entry_t                             out_q, out_d;
    logic [instructionCounterWidth-1:0] maj_id_q, maj_id_d;
    logic [instructionCounterWidth-1:0] cnt_q, cnt_d;
    logic [TW-1:0]                      grant_q, grant_d;
    logic [TW-1:0]                      last_grant_q, last_grant_d;
    logic [TW-1:0]                      cand, win_idx;
    logic                               found;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 1; k <= numThreads; k++) begin
            cand = TW'((int'(last_grant_q) + k) % numThreads);
            if (!found && eligible[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        enable_d     = enable_q;
        out_d        = out_q;
        maj_id_d     = maj_id_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pop          = '0;
        if (stall_i) begin
            // Held issue belongs to a thread being flushed: withdraw it.
            if (enable_q && flush_i[grant_q]) begin
                enable_d = 1'b0;
            end
        end else if (found) begin
            pop[win_idx] = 1'b1;
            enable_d     = 1'b1;
            out_d        = head[win_idx];
            maj_id_d     = cnt_q;
            cnt_d        = cnt_q + 1'b1;
            grant_d      = win_idx;
            last_grant_d = win_idx;
        end else begin
            enable_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            enable_q     <= 1'b0;
            out_q        <= '0;
            maj_id_q     <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= TW'(numThreads - 1);
        end else begin
            enable_q     <= enable_d;
            out_q        <= out_d;
            maj_id_q     <= maj_id_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign enable_o             = enable_q;
    assign instruction_o        = out_q.inst;
    assign instructionAddress_o = out_q.addr;
    assign is64Bit_o            = out_q.is64;
    assign instructionPid_o     = out_q.pid;
    assign instructionTid_o     = out_q.tid;
    assign instructionMajId_o   = maj_id_q;
    assign grantThread_o        = grant_q;

`ifdef DECODE_ARB_PERF_EN
    logic [31:0] issue_count_q, issue_count_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        issue_count_d  = issue_count_q;
        stall_cycles_d = stall_cycles_q;
        if (!stall_i && found && (issue_count_q != '1)) begin
            issue_count_d = issue_count_q + 1'b1;
        end
        if (stall_i && enable_q && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            issue_count_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            issue_count_q  <= issue_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign issueCount_o  = issue_count_q;
    assign stallCycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_decode_issue_arbiter.sv
module tb_decode_issue_arbiter;

    localparam int NT = 2;

    logic            clock_i = 1'b0;
    logic            reset_i;
    logic [NT-1:0]   fetchValid_i;
    logic [NT-1:0]   fetchReady_o;
    logic [NT*32-1:0] fetchInst_i;
    logic [NT*64-1:0] fetchAddr_i;
    logic [NT-1:0]   fetchIs64Bit_i;
    logic [NT*20-1:0] fetchPid_i;
    logic [NT*16-1:0] fetchTid_i;
    logic [NT-1:0]   flush_i;
    logic            stall_i;
    logic            enable_o;
    logic [31:0]     instruction_o;
    logic [63:0]     instructionAddress_o;
    logic            is64Bit_o;
    logic [19:0]     instructionPid_o;
    logic [15:0]     instructionTid_o;
    logic [3:0]      instructionMajId_o;
    logic [0:0]      grantThread_o;
`ifdef DECODE_ARB_PERF_EN
    logic [31:0]     issueCount_o;
    logic [31:0]     stallCycles_o;
`endif

    int tests = 0;
    int fails = 0;

    decode_issue_arbiter #(
        .addressWidth            (64),
        .instructionWidth        (32),
        .PidSize                 (20),
        .TidSize                 (16),
        .instructionCounterWidth (4),
        .numThreads              (NT),
        .queueDepth              (4)
    ) dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .fetchValid_i         (fetchValid_i),
        .fetchReady_o         (fetchReady_o),
        .fetchInst_i          (fetchInst_i),
        .fetchAddr_i          (fetchAddr_i),
        .fetchIs64Bit_i       (fetchIs64Bit_i),
        .fetchPid_i           (fetchPid_i),
        .fetchTid_i           (fetchTid_i),
        .flush_i              (flush_i),
        .stall_i              (stall_i),
        .enable_o             (enable_o),
        .instruction_o        (instruction_o),
        .instructionAddress_o (instructionAddress_o),
        .is64Bit_o            (is64Bit_o),
        .instructionPid_o     (instructionPid_o),
        .instructionTid_o     (instructionTid_o),
        .instructionMajId_o   (instructionMajId_o),
        .grantThread_o        (grantThread_o)
`ifdef DECODE_ARB_PERF_EN
        ,
        .issueCount_o         (issueCount_o),
        .stallCycles_o        (stallCycles_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Thread 0 fields sit at the MSBs of every packed vector.
    task automatic set_push(input logic [1:0] valid, input logic [31:0] i0, input logic [31:0] i1);
        fetchValid_i = valid;
        fetchInst_i  = {i0, i1};
        fetchAddr_i  = {32'hA000_0000, i0, 32'hB000_0000, i1};
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        stall_i = 1'b0;
        flush_i = '0;
        set_push(2'b00, 32'h0, 32'h0);
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    initial begin
        fetchIs64Bit_i = 2'b01;
        fetchPid_i     = {20'h12345, 20'h0ABCD};
        fetchTid_i     = {16'h0111, 16'h0222};
        reset_i = 1'b1;
        stall_i = 1'b0;
        flush_i = '0;
        set_push(2'b00, 32'h0, 32'h0);
        tick();
        tick();
        check("rst_ready",  64'(fetchReady_o), 64'h0);
        check("rst_enable", 64'(enable_o), 64'h0);
        check("rst_inst",   64'(instruction_o), 64'h0);
        check("rst_majid",  64'(instructionMajId_o), 64'h0);
        check("rst_grant",  64'(grantThread_o), 64'h0);
        reset_i = 1'b0;

        // Single push on thread 0: two-cycle latency to enable_o.
        set_push(2'b01, 32'hFC00_002A, 32'h0);
        tick();
        set_push(2'b00, 32'h0, 32'h0);
        check("lat_enable_early", 64'(enable_o), 64'h0);
        tick();
        check("lat_enable", 64'(enable_o), 64'h1);
        check("lat_inst",   64'(instruction_o), 64'hFC00_002A);
        check("lat_addr",   instructionAddress_o, 64'hA000_0000_FC00_002A);
        check("lat_is64",   64'(is64Bit_o), 64'h1);
        check("lat_pid",    64'(instructionPid_o), 64'h12345);
        check("lat_tid",    64'(instructionTid_o), 64'h0111);
        check("lat_majid",  64'(instructionMajId_o), 64'h0);
        check("lat_grant",  64'(grantThread_o), 64'h0);
        tick();
        check("lat_idle_enable", 64'(enable_o), 64'h0);
        check("lat_idle_hold",   64'(instruction_o), 64'hFC00_002A);

        // Both threads full, then round-robin drain.
        do_reset();
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_push(2'b11, 32'h100 + 32'(i), 32'h200 + 32'(i));
            tick();
        end
        set_push(2'b00, 32'h0, 32'h0);
        check("fill_ready",  64'(fetchReady_o), 64'h0);
        check("fill_enable", 64'(enable_o), 64'h0);
        stall_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr_enable", 64'(enable_o), 64'h1);
            check("rr_grant",  64'(grantThread_o), 64'(i % 2));
            check("rr_inst",   64'(instruction_o), ((i % 2) == 1) ? 64'(32'h200 + 32'(i / 2)) : 64'(32'h100 + 32'(i / 2)));
            check("rr_majid",  64'(instructionMajId_o), 64'(i));
            if (i == 1) begin
                check("rr_t1_pid",  64'(instructionPid_o), 64'h0ABCD);
                check("rr_t1_is64", 64'(is64Bit_o), 64'h0);
                check("rr_t1_addr", instructionAddress_o, 64'hB000_0000_0000_0200);
            end
        end
        tick();
        check("rr_drained", 64'(enable_o), 64'h0);

        // Thread 1 full under stall; a fifth push must be refused.
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_push(2'b10, 32'h0, 32'h300 + 32'(i));
            tick();
        end
        check("full_ready", 64'(fetchReady_o), 64'h1);
        set_push(2'b10, 32'h0, 32'h3FF);
        tick();
        set_push(2'b00, 32'h0, 32'h0);
        check("full_ready_hold", 64'(fetchReady_o), 64'h1);
        check("full_stall_enable", 64'(enable_o), 64'h0);
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("full_enable", 64'(enable_o), 64'h1);
            check("full_grant",  64'(grantThread_o), 64'h1);
            check("full_inst",   64'(instruction_o), 64'(32'h300 + 32'(i)));
            check("full_majid",  64'(instructionMajId_o), 64'(8 + i));
            if (i == 0) check("full_ready_after_pop", 64'(fetchReady_o), 64'h3);
        end
        tick();
        check("full_fifth_dropped", 64'(enable_o), 64'h0);

        // Stall for three cycles mid-stream.
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_push(2'b01, 32'h400 + 32'(i), 32'h0);
            tick();
        end
        set_push(2'b00, 32'h0, 32'h0);
        stall_i = 1'b0;
        tick();
        check("stl_inst0",  64'(instruction_o), 64'h400);
        check("stl_majid0", 64'(instructionMajId_o), 64'd12);
        tick();
        check("stl_inst1",  64'(instruction_o), 64'h401);
        check("stl_majid1", 64'(instructionMajId_o), 64'd13);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_hold_enable", 64'(enable_o), 64'h1);
            check("stl_hold_inst",   64'(instruction_o), 64'h401);
            check("stl_hold_majid",  64'(instructionMajId_o), 64'd13);
        end
        stall_i = 1'b0;
        tick();
        check("stl_inst2",  64'(instruction_o), 64'h402);
        check("stl_majid2", 64'(instructionMajId_o), 64'd14);
        tick();
        check("stl_inst3",  64'(instruction_o), 64'h403);
        check("stl_majid3", 64'(instructionMajId_o), 64'd15);
        tick();
        check("stl_drained", 64'(enable_o), 64'h0);

        // Flush thread 0 (3 entries, push arriving) while thread 1 issues;
        // the first issue here also shows the major ID wrapping 15 -> 0.
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_push(2'b11, 32'h500 + 32'(i), 32'h600 + 32'(i));
            tick();
        end
        stall_i = 1'b0;
        flush_i = 2'b01;
        set_push(2'b01, 32'h5FF, 32'h0);
        tick();
        flush_i = 2'b00;
        set_push(2'b00, 32'h0, 32'h0);
        check("fl_enable",  64'(enable_o), 64'h1);
        check("fl_grant",   64'(grantThread_o), 64'h1);
        check("fl_inst",    64'(instruction_o), 64'h600);
        check("wrap_majid", 64'(instructionMajId_o), 64'h0);
        check("fl_ready",   64'(fetchReady_o), 64'h3);
        tick();
        check("fl_grant1",  64'(grantThread_o), 64'h1);
        check("fl_inst1",   64'(instruction_o), 64'h601);
        check("fl_majid1",  64'(instructionMajId_o), 64'h1);
        tick();
        check("fl_grant2",  64'(grantThread_o), 64'h1);
        check("fl_inst2",   64'(instruction_o), 64'h602);
        check("fl_majid2",  64'(instructionMajId_o), 64'h2);
        tick();
        check("fl_drained", 64'(enable_o), 64'h0);

        // Flush while stalled withdraws the held issue only for its own thread.
        set_push(2'b01, 32'h700, 32'h0);
        tick();
        set_push(2'b00, 32'h0, 32'h0);
        tick();
        check("fs_enable", 64'(enable_o), 64'h1);
        check("fs_inst",   64'(instruction_o), 64'h700);
        check("fs_majid",  64'(instructionMajId_o), 64'h3);
        check("fs_grant",  64'(grantThread_o), 64'h0);
        stall_i = 1'b1;
        flush_i = 2'b10;
        tick();
        check("fs_other_keeps", 64'(enable_o), 64'h1);
        flush_i = 2'b01;
        tick();
        check("fs_cleared", 64'(enable_o), 64'h0);
        check("fs_inst_hold", 64'(instruction_o), 64'h700);
        stall_i = 1'b0;
        flush_i = 2'b00;
        tick();
        check("fs_idle", 64'(enable_o), 64'h0);
        check("fs_majid_hold", 64'(instructionMajId_o), 64'h3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
